// File: rtl/cdf_pipe_sequencer.sv
// Run-level sequencer for the CDF pipeline: arms the fetch stage, counts bins,
// delays per-bin valid to the store stage, drains, and reports done or error.
module cdf_pipe_sequencer #(
  parameter int NUM_BINS   = 256,
  parameter int PIPE_DEPTH = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic       abort,
  input  logic       stage_valid,
  output logic       start_out,
  output logic       wr_en_out,
  output logic [8:0] bin_count,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(PIPE_DEPTH + 1);

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DR_LAST  = DW'(PIPE_DEPTH - 1);
  localparam logic [8:0]    BIN_MAX  = 9'(NUM_BINS);
  localparam logic [8:0]    BIN_LAST = 9'(NUM_BINS - 1);

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic [TW-1:0]         tcnt;
  logic [DW-1:0]         dcnt;
  logic [PIPE_DEPTH-1:0] wr_sr;
  logic                  run_valid;

  assign run_valid = stage_valid && (state == S_RUN);
  assign wr_en_out = wr_sr[PIPE_DEPTH-1];
  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (go && !abort) state_nx = S_ARM;
      S_ARM:   state_nx = S_RUN;
      S_RUN: begin
        if (stage_valid && bin_count == BIN_LAST)
          state_nx = S_DRAIN;
        else if (!stage_valid && tcnt == TO_LAST)
          state_nx = S_ERR;
      end
      S_DRAIN: if (dcnt == DR_LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      start_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      bin_count <= 9'd0;
      tcnt      <= '0;
      dcnt      <= '0;
    end else begin
      state     <= state_nx;
      start_out <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
      busy      <= (state_nx != S_IDLE);
      done      <= (state_nx == S_DONE);
      if (state_nx == S_ERR)
        error <= 1'b1;
      if (state == S_IDLE && state_nx == S_ARM) begin
        bin_count <= 9'd0;
        tcnt      <= '0;
        error     <= 1'b0;
      end else if (state == S_RUN && !abort) begin
        if (stage_valid) begin
          tcnt <= '0;
          if (bin_count != BIN_MAX)
            bin_count <= bin_count + 9'd1;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
      if (state == S_DRAIN)
        dcnt <= dcnt + DW'(1);
      else
        dcnt <= '0;
    end
  end

  // abort discards bins still in flight toward the store stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_sr <= '0;
    end else if (abort) begin
      wr_sr <= '0;
    end else begin
      wr_sr[0] <= run_valid;
      for (int i = 1; i < PIPE_DEPTH; i++)
        wr_sr[i] <= wr_sr[i-1];
    end
  end

endmodule

// File: tb/tb_cdf_pipe_sequencer.sv
// Scoreboard bench for cdf_pipe_sequencer: stimulus queues expected
// wr_en/done cycles, a negedge monitor pops and compares them.
module tb_cdf_pipe_sequencer;

  logic       clock;
  logic       reset_n;
  logic       go;
  logic       abort;
  logic       stage_valid;
  logic       start_out;
  logic       wr_en_out;
  logic [8:0] bin_count;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_q[$];
  int done_q[$];

  cdf_pipe_sequencer #(
    .NUM_BINS(256),
    .PIPE_DEPTH(3),
    .TIMEOUT(64)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .go(go),
    .abort(abort),
    .stage_valid(stage_valid),
    .start_out(start_out),
    .wr_en_out(wr_en_out),
    .bin_count(bin_count),
    .busy(busy),
    .done(done),
    .error(error),
    .state_dbg(state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // monitor: compare outputs against queued expectations
  always @(negedge clock) begin
    if (reset_n) begin
      logic exp_w;
      logic exp_d;
      exp_w = (wr_q.size() > 0) && (wr_q[0] == cyc);
      exp_d = (done_q.size() > 0) && (done_q[0] == cyc);
      if (exp_w || wr_en_out) begin
        checks++;
        if (wr_en_out !== exp_w) begin
          failures++;
          $display("FAIL wr_en cycle=%0d act=%0b exp=%0b",
                   cyc, wr_en_out, exp_w);
        end
      end
      if (exp_w) void'(wr_q.pop_front());
      if (exp_d || done) begin
        checks++;
        if (done !== exp_d) begin
          failures++;
          $display("FAIL done cycle=%0d act=%0b exp=%0b",
                   cyc, done, exp_d);
        end
      end
      if (exp_d) void'(done_q.pop_front());
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v);
    stage_valid = v;
    if (v) wr_q.push_back(cyc + 3);
    step();
  endtask

  task automatic start_pass(input string nm);
    go = 1'b1;
    step();
    go = 1'b0;
    chk({nm, "_arm_state"}, state_dbg, 1);
    chk({nm, "_arm_err"}, error, 0);
    chk({nm, "_arm_cnt"}, bin_count, 0);
    chk({nm, "_arm_start"}, start_out, 0);
    step();
    chk({nm, "_run_state"}, state_dbg, 2);
    chk({nm, "_run_start"}, start_out, 1);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    stage_valid = 1'b0;
    while (wr_q.size() > 0 && wr_q[$] > cyc) void'(wr_q.pop_back());
    step();
    abort = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    go          = 1'b1;
    abort       = 1'b0;
    stage_valid = 1'b0;
    step();
    step();
    chk("rst_state", state_dbg, 0);
    chk("rst_start", start_out, 0);
    chk("rst_wr", wr_en_out, 0);
    chk("rst_cnt", bin_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {done, error}, 0);
    go = 1'b0;
    reset_n = 1'b1;
    step();
    step();
    chk("rel_state", state_dbg, 0);

    // nominal: 256 back-to-back valids
    start_pass("nom");
    for (int i = 0; i < 256; i++) drive(1'b1);
    stage_valid = 1'b0;
    done_q.push_back(cyc + 3);
    chk("nom_drain", state_dbg, 3);
    chk("nom_cnt", bin_count, 256);
    chk("nom_drain_start", start_out, 1);
    step();
    step();
    step();
    chk("nom_done_state", state_dbg, 4);
    chk("nom_done_start", start_out, 0);
    chk("nom_done_busy", busy, 1);
    step();
    chk("nom_idle", state_dbg, 0);
    chk("nom_idle_busy", busy, 0);
    chk("nom_hold_cnt", bin_count, 256);

    // stall: 100 valids then 64 idle cycles
    start_pass("stl");
    for (int i = 0; i < 100; i++) drive(1'b1);
    for (int i = 0; i < 63; i++) drive(1'b0);
    chk("stl_still_run", state_dbg, 2);
    drive(1'b0);
    chk("stl_err_state", state_dbg, 5);
    chk("stl_err", error, 1);
    chk("stl_start", start_out, 0);
    chk("stl_busy", busy, 1);
    chk("stl_cnt", bin_count, 100);
    step();
    chk("stl_idle", state_dbg, 0);
    chk("stl_err_kept", error, 1);

    // abort at bin 50 (go clears error in ARM)
    start_pass("abt");
    for (int i = 0; i < 50; i++) drive(1'b1);
    do_abort();
    chk("abt_state", state_dbg, 0);
    chk("abt_start", start_out, 0);
    chk("abt_wr", wr_en_out, 0);
    chk("abt_cnt", bin_count, 50);
    for (int i = 0; i < 6; i++) step();

    // go with abort in IDLE stays idle
    go = 1'b1;
    abort = 1'b1;
    step();
    go = 1'b0;
    abort = 1'b0;
    chk("prio_idle", state_dbg, 0);

    // go while running is ignored
    start_pass("gor");
    for (int i = 0; i < 10; i++) drive(1'b1);
    go = 1'b1;
    drive(1'b1);
    go = 1'b0;
    chk("gor_state", state_dbg, 2);
    chk("gor_cnt", bin_count, 11);
    do_abort();
    for (int i = 0; i < 6; i++) step();

    // gapped valid 1,0,1,0...
    start_pass("gap");
    for (int i = 0; i < 256; i++) begin
      drive(1'b1);
      if (i < 255) drive(1'b0);
    end
    stage_valid = 1'b0;
    done_q.push_back(cyc + 3);
    chk("gap_drain", state_dbg, 3);
    chk("gap_cnt", bin_count, 256);
    step();
    step();
    step();
    chk("gap_done", state_dbg, 4);
    chk("gap_noerr", error, 0);
    step();
    step();
    chk("gap_idle", state_dbg, 0);

    chk("wr_q_empty", wr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
